dmem_write_buffer: RTL and testbench
====================================

# dmem_write_buffer

Posted-write buffer and read controller between the single-cycle datapath's data-memory port and a slower, handshaked data memory. Stores are queued and retired in the background. Loads are forwarded from the buffer on a hit; on a miss the datapath is stalled until the buffer drains and the memory returns data. The datapath drives address, store data, MemRead and MemWrite. It receives load data plus a stall that freezes PC and register writeback.

## Interface
- DEPTH, 4, buffer entries; power of two, ≥2
- AW, 32, address width
- CLK  in  1  clock; all state updates on posedge
- Reset_L  in  1  reset Reset_L, asynchronous, active-low
- cpu_addr  in  AW  byte address (ALU result)
- cpu_wdata  in  32  store data
- MemRead  in  1  load request
- MemWrite  in  1  store request
- cpu_rdata  out  32  load data
- stall  out  1  datapath must hold its request and state while high
- mem_req  out  1  memory request, registered
- mem_we  out  1  1=write, 0=read, registered
- mem_addr  out  AW  memory address, registered
- mem_wdata  out  32  memory write data, registered
- mem_ack  in  1  memory completion; sampled only while mem_req=1
- mem_rdata  in  32  read data, valid in the mem_ack cycle

## Operation
- Buffer: circular FIFO of {addr, data}, plus head/tail pointers and a count register (0..DEPTH).
- Word match compares addr[AW-1:2]; low two bits are ignored for matching but passed unchanged to memory.
- Store (MemWrite=1):
  - If count<DEPTH, enqueue at posedge; stall=0.
  - If full, stall=1 until a pop frees an entry; enqueue occurs at the posedge where count<DEPTH.
- MemRead=1 together with MemWrite=1 is treated as a store only.
- Load hit (MemRead=1, MemWrite=0, any valid entry matches): cpu_rdata = data of the youngest matching entry, combinational; stall=0.
- Load miss:
  - stall=1 from the first cycle.
  - The buffer drains completely.
  - A read is issued, then the result is returned.
- FSM states:
  - IDLE: if a load miss is pending and count=0, go to RD_WAIT and issue the read. Else if count>0, go to WR_WAIT and issue head entry as a write. Else stay.
  - WR_WAIT: hold mem_req/we/addr/wdata. On mem_ack, pop head, drop mem_req, go to IDLE.
  - RD_WAIT: hold the read request. On mem_ack, capture mem_rdata into rd_buf, drop mem_req, go to RD_DONE.
  - RD_DONE: cpu_rdata=rd_buf, stall=0 for exactly this cycle, then go to IDLE.
- Read-miss priority is only over new enqueues; the miss waits for all older writes to retire, so program order is preserved.
- A simultaneous enqueue and pop leaves count unchanged; both pointers advance and wrap modulo DEPTH.
- cpu_rdata = 0 when no load is being returned.

## Timing
- Reset (async assert): FSM=IDLE, count=0, pointers=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_buf=0. stall and cpu_rdata then read 0.
- Reset mid-transaction abandons the outstanding request with no completion; buffered writes are lost.
- mem_req rises one cycle after the FSM leaves IDLE and stays high through the mem_ack cycle. It falls on the following posedge; there are no back-to-back requests.
- Minimum cost per retired write: ack latency + 2 cycles.
- Minimum load-miss latency with an empty buffer and ack on the first request cycle: 3 cycles of stall. The data is visible in the 4th cycle, with stall=0.
- Load hit and non-full store: zero stall cycles.
- A store enqueued while a write is in flight does not disturb mem_addr/mem_wdata.

## Test plan
- Reset with Reset_L=0 mid-WR_WAIT → mem_req=0 immediately. After release: count=0, stall=0, cpu_rdata=0.
- Stores to 0x10=0xAAAA0001 and then 0x20=0x00000002, with mem_ack delayed 3 cycles → no stall. Memory sees two writes in order with the exact addr/data, mem_req high 4 cycles each.
- Store 0x40=0x1111, store 0x40=0x2222, then load 0x42 before drain → cpu_rdata=0x2222 same cycle, stall=0.
- Five stores with mem_ack held low (DEPTH=4) → 5th store sees stall=1. Raise mem_ack once → 5th store enqueued the cycle after the pop; count stays 4.
- Two stores pending, then load miss at 0x80 with memory returning 0xDEADBEEF → both writes retire first, then one read at 0x80. cpu_rdata=0xDEADBEEF with stall=0 for exactly one cycle.
- MemRead=MemWrite=1 at 0x8, data 0x5 → treated as store (queued write), no read issued.

Source files
------------

// File: rtl/dmem_write_buffer.sv
// Posted-write buffer between the datapath data port and a handshaked data memory.
// Stores retire in the background; loads forward from the buffer or stall on a miss.
module dmem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          CLK,
  input  logic          Reset_L,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic          MemRead,
  input  logic          MemWrite,
  output logic [31:0]   cpu_rdata,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, RD_DONE} state_t;

  state_t        state, state_next;
  logic [AW-1:0] buf_addr [DEPTH];
  logic [31:0]   buf_data [DEPTH];
  logic [PW-1:0] head, tail, idx;
  logic [CW-1:0] count;
  logic [31:0]   rd_buf, hit_data;
  logic          hit, load, miss, full, enq, pop;

  assign full = (count == CW'(DEPTH));
  assign load = MemRead && !MemWrite;
  assign miss = load && !hit;
  assign enq  = MemWrite && !full;
  assign pop  = (state == WR_WAIT) && mem_req && mem_ack;

  // Scan oldest to youngest so the last match wins; low two address bits ignored.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (buf_addr[idx][AW-1:2] == cpu_addr[AW-1:2])) begin
        hit      = 1'b1;
        hit_data = buf_data[idx];
      end
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    cpu_rdata  = '0;
    case (state)
      IDLE:
        if (miss && (count == '0))
          state_next = RD_WAIT;
        else if (count != '0)
          state_next = WR_WAIT;
      WR_WAIT:
        if (mem_req && mem_ack)
          state_next = IDLE;
      RD_WAIT:
        if (mem_req && mem_ack)
          state_next = RD_DONE;
      RD_DONE:
        state_next = IDLE;
      default:
        state_next = IDLE;
    endcase
    if (state == RD_DONE)
      cpu_rdata = rd_buf;
    else if (load && hit)
      cpu_rdata = hit_data;
    if (state != RD_DONE)
      stall = miss || (MemWrite && full);
  end

  // Request fields are captured on leaving IDLE; mem_req follows one cycle later.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_buf    <= '0;
    end else begin
      state <= state_next;
      if (enq)
        tail <= tail + PW'(1);
      if (pop)
        head <= head + PW'(1);
      count <= count + CW'(enq) - CW'(pop);
      if ((state == IDLE) && (state_next == WR_WAIT)) begin
        mem_we    <= 1'b1;
        mem_addr  <= buf_addr[head];
        mem_wdata <= buf_data[head];
      end else if ((state == IDLE) && (state_next == RD_WAIT)) begin
        mem_we    <= 1'b0;
        mem_addr  <= cpu_addr;
        mem_wdata <= '0;
      end
      if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
        if (state == RD_WAIT)
          rd_buf <= mem_rdata;
      end else if (((state == WR_WAIT) || (state == RD_WAIT)) && !mem_req) begin
        mem_req <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      buf_addr[tail] <= cpu_addr;
      buf_data[tail] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Bench for dmem_write_buffer: a memory responder logs every completed request,
// and each test queues the transactions it expects and compares them in order.
module tb_dmem_write_buffer;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          len;
  } txn_t;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int          tests = 0;
  int          fails = 0;
  txn_t        exp_q[$];
  txn_t        obs_q[$];
  int          obs_rd = 0;
  bit          ack_hold = 1'b0;
  int          ack_delay = 0;
  int          once_req = 0;
  int          once_done = 0;
  int          req_cnt = 0;
  logic [31:0] rd_value = '0;

  always #5 CLK = ~CLK;

  dmem_write_buffer #(.DEPTH(4), .AW(32)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Memory model: acks after ack_delay extra request cycles, or on a one-shot grant while held.
  always @(posedge CLK) begin
    #3;
    if (!Reset_L || !mem_req) begin
      req_cnt   = 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
    end else begin
      req_cnt++;
      if ((!ack_hold && req_cnt > ack_delay) || (once_req != once_done)) begin
        once_done = once_req;
        mem_ack   = 1'b1;
        mem_rdata = mem_we ? 32'h0 : rd_value;
        obs_q.push_back('{mem_we, mem_addr, mem_wdata, req_cnt});
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
      end
    end
  end

  task automatic drive(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
    @(posedge CLK);
    #1;
    MemWrite  = wr;
    MemRead   = rd;
    cpu_addr  = a;
    cpu_wdata = d;
    @(negedge CLK);
  endtask

  task automatic push_exp(input logic we, input logic [31:0] a, input logic [31:0] d, input int len);
    exp_q.push_back('{we, a, d, len});
  endtask

  task automatic wait_obs(input int n, output bit ok);
    int guard = 0;
    while ((obs_q.size() < obs_rd + n) && (guard < 200)) begin
      @(negedge CLK);
      guard++;
    end
    ok = (obs_q.size() >= obs_rd + n);
  endtask

  task automatic test_reset();
    bit ok;
    int n;
    txn_t e, o;
    Reset_L = 1'b0;
    repeat (2) @(negedge CLK);
    tests++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        stall !== 1'b0 || cpu_rdata !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_state: got req=%b we=%b addr=%h wdata=%h stall=%b rdata=%h, required all zero",
               mem_req, mem_we, mem_addr, mem_wdata, stall, cpu_rdata);
    end
    Reset_L  = 1'b1;
    ack_hold = 1'b1;
    drive(1'b1, 1'b0, 32'h100, 32'h77);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    tests++;
    if (mem_req !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_wr_wait: got mem_req=%b, required 1", mem_req);
    end
    @(posedge CLK);
    #2 Reset_L = 1'b0;
    #1;
    tests++;
    if (mem_req !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_async: got mem_req=%b, required 0", mem_req);
    end
    @(negedge CLK);
    Reset_L  = 1'b1;
    obs_rd   = obs_q.size();
    exp_q.delete();
    ack_hold = 1'b0;
    ack_delay = 0;
    rd_value = 32'hCAFEF00D;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tests++;
    if (stall !== 1'b0 || cpu_rdata !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_release: got stall=%b rdata=%h, required 0 and 0", stall, cpu_rdata);
    end
    // The lost store must not forward or drain: the load goes straight to memory.
    n = 0;
    drive(1'b0, 1'b1, 32'h100, 32'h0);
    while (stall === 1'b1 && n < 50) begin
      n++;
      drive(1'b0, 1'b1, 32'h100, 32'h0);
    end
    tests++;
    if (n != 3 || cpu_rdata !== 32'hCAFEF00D) begin
      fails++;
      $display("[TB] FAIL reset_cleared: got %0d stall cycles rdata=%h, required 3 and cafef00d", n, cpu_rdata);
    end
    push_exp(1'b0, 32'h100, 32'h0, 0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    wait_obs(exp_q.size(), ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL reset_timeout: got %0d txns, required %0d", obs_q.size() - obs_rd, exp_q.size());
      exp_q.delete();
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      tests++;
      if (o.we !== e.we || o.addr !== e.addr || (e.we && o.data !== e.data)) begin
        fails++;
        $display("[TB] FAIL reset_txn: got we=%b addr=%h data=%h, required we=%b addr=%h data=%h",
                 o.we, o.addr, o.data, e.we, e.addr, e.data);
      end
    end
  endtask

  task automatic test_posted_writes();
    bit ok;
    txn_t e, o;
    ack_hold  = 1'b0;
    ack_delay = 3;
    drive(1'b1, 1'b0, 32'h10, 32'hAAAA0001);
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("[TB] FAIL posted_stall1: got stall=%b, required 0", stall);
    end
    push_exp(1'b1, 32'h10, 32'hAAAA0001, 4);
    drive(1'b1, 1'b0, 32'h20, 32'h00000002);
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("[TB] FAIL posted_stall2: got stall=%b, required 0", stall);
    end
    push_exp(1'b1, 32'h20, 32'h00000002, 4);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    wait_obs(exp_q.size(), ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL posted_timeout: got %0d txns, required %0d", obs_q.size() - obs_rd, exp_q.size());
      exp_q.delete();
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      tests++;
      if (o.we !== e.we || o.addr !== e.addr || o.data !== e.data || o.len != e.len) begin
        fails++;
        $display("[TB] FAIL posted_txn: got we=%b addr=%h data=%h len=%0d, required we=%b addr=%h data=%h len=%0d",
                 o.we, o.addr, o.data, o.len, e.we, e.addr, e.data, e.len);
      end
    end
  endtask

  task automatic test_forward();
    bit ok;
    txn_t e, o;
    ack_hold = 1'b1;
    drive(1'b1, 1'b0, 32'h40, 32'h1111);
    push_exp(1'b1, 32'h40, 32'h1111, 0);
    drive(1'b1, 1'b0, 32'h40, 32'h2222);
    push_exp(1'b1, 32'h40, 32'h2222, 0);
    drive(1'b0, 1'b1, 32'h42, 32'h0);
    tests++;
    if (cpu_rdata !== 32'h2222 || stall !== 1'b0) begin
      fails++;
      $display("[TB] FAIL forward_hit: got rdata=%h stall=%b, required 00002222 and 0", cpu_rdata, stall);
    end
    drive(1'b0, 1'b0, 32'h42, 32'h0);
    tests++;
    if (cpu_rdata !== 32'h0) begin
      fails++;
      $display("[TB] FAIL forward_idle: got rdata=%h, required 0", cpu_rdata);
    end
    ack_hold  = 1'b0;
    ack_delay = 0;
    wait_obs(exp_q.size(), ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL forward_timeout: got %0d txns, required %0d", obs_q.size() - obs_rd, exp_q.size());
      exp_q.delete();
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      tests++;
      if (o.we !== e.we || o.addr !== e.addr || o.data !== e.data) begin
        fails++;
        $display("[TB] FAIL forward_txn: got we=%b addr=%h data=%h, required we=%b addr=%h data=%h",
                 o.we, o.addr, o.data, e.we, e.addr, e.data);
      end
    end
  endtask

  task automatic test_full();
    bit ok;
    txn_t e, o;
    ack_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'(i + 1));
      push_exp(1'b1, 32'h300 + 32'(4 * i), 32'(i + 1), 0);
      tests++;
      if (stall !== 1'b0) begin
        fails++;
        $display("[TB] FAIL full_fill%0d: got stall=%b, required 0", i, stall);
      end
    end
    drive(1'b1, 1'b0, 32'h310, 32'h5);
    tests++;
    if (stall !== 1'b1) begin
      fails++;
      $display("[TB] FAIL full_stall: got stall=%b, required 1", stall);
    end
    once_req++;
    drive(1'b1, 1'b0, 32'h310, 32'h5);
    tests++;
    if (stall !== 1'b1) begin
      fails++;
      $display("[TB] FAIL full_pop_cycle: got stall=%b, required 1", stall);
    end
    drive(1'b1, 1'b0, 32'h310, 32'h5);
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("[TB] FAIL full_enq: got stall=%b, required 0", stall);
    end
    push_exp(1'b1, 32'h310, 32'h5, 0);
    drive(1'b1, 1'b0, 32'h314, 32'h6);
    tests++;
    if (stall !== 1'b1) begin
      fails++;
      $display("[TB] FAIL full_count: got stall=%b, required 1", stall);
    end
    ack_hold  = 1'b0;
    ack_delay = 0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    wait_obs(exp_q.size(), ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL full_timeout: got %0d txns, required %0d", obs_q.size() - obs_rd, exp_q.size());
      exp_q.delete();
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      tests++;
      if (o.we !== e.we || o.addr !== e.addr || o.data !== e.data) begin
        fails++;
        $display("[TB] FAIL full_txn: got we=%b addr=%h data=%h, required we=%b addr=%h data=%h",
                 o.we, o.addr, o.data, e.we, e.addr, e.data);
      end
    end
  endtask

  task automatic test_load_miss();
    bit ok;
    int n;
    txn_t e, o;
    ack_hold = 1'b1;
    drive(1'b1, 1'b0, 32'h200, 32'hA);
    push_exp(1'b1, 32'h200, 32'hA, 0);
    drive(1'b1, 1'b0, 32'h204, 32'hB);
    push_exp(1'b1, 32'h204, 32'hB, 0);
    ack_hold  = 1'b0;
    ack_delay = 1;
    rd_value  = 32'hDEADBEEF;
    drive(1'b0, 1'b1, 32'h80, 32'h0);
    tests++;
    if (stall !== 1'b1) begin
      fails++;
      $display("[TB] FAIL miss_first: got stall=%b, required 1", stall);
    end
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      drive(1'b0, 1'b1, 32'h80, 32'h0);
    end
    tests++;
    if (stall !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("[TB] FAIL miss_data: got stall=%b rdata=%h, required 0 and deadbeef", stall, cpu_rdata);
    end
    push_exp(1'b0, 32'h80, 32'h0, 0);
    // Holding the load one more cycle must start a fresh miss, not repeat the data.
    ack_delay = 0;
    rd_value  = 32'h12345678;
    drive(1'b0, 1'b1, 32'h80, 32'h0);
    tests++;
    if (stall !== 1'b1 || cpu_rdata !== 32'h0) begin
      fails++;
      $display("[TB] FAIL miss_one_cycle: got stall=%b rdata=%h, required 1 and 0", stall, cpu_rdata);
    end
    n = 1;
    while (stall === 1'b1 && n < 100) begin
      drive(1'b0, 1'b1, 32'h80, 32'h0);
      if (stall === 1'b1) n++;
    end
    tests++;
    if (n != 3 || cpu_rdata !== 32'h12345678) begin
      fails++;
      $display("[TB] FAIL miss_latency: got %0d stall cycles rdata=%h, required 3 and 12345678", n, cpu_rdata);
    end
    push_exp(1'b0, 32'h80, 32'h0, 0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tests++;
    if (stall !== 1'b0 || cpu_rdata !== 32'h0) begin
      fails++;
      $display("[TB] FAIL miss_idle: got stall=%b rdata=%h, required 0 and 0", stall, cpu_rdata);
    end
    wait_obs(exp_q.size(), ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL miss_timeout: got %0d txns, required %0d", obs_q.size() - obs_rd, exp_q.size());
      exp_q.delete();
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      tests++;
      if (o.we !== e.we || o.addr !== e.addr || (e.we && o.data !== e.data)) begin
        fails++;
        $display("[TB] FAIL miss_txn: got we=%b addr=%h data=%h, required we=%b addr=%h data=%h",
                 o.we, o.addr, o.data, e.we, e.addr, e.data);
      end
    end
  endtask

  task automatic test_read_write_both();
    bit ok;
    txn_t e, o;
    ack_hold  = 1'b0;
    ack_delay = 0;
    drive(1'b1, 1'b1, 32'h8, 32'h5);
    tests++;
    if (stall !== 1'b0 || cpu_rdata !== 32'h0) begin
      fails++;
      $display("[TB] FAIL rdwr_store: got stall=%b rdata=%h, required 0 and 0", stall, cpu_rdata);
    end
    push_exp(1'b1, 32'h8, 32'h5, 0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    wait_obs(exp_q.size(), ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL rdwr_timeout: got %0d txns, required %0d", obs_q.size() - obs_rd, exp_q.size());
      exp_q.delete();
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      tests++;
      if (o.we !== e.we || o.addr !== e.addr || o.data !== e.data) begin
        fails++;
        $display("[TB] FAIL rdwr_txn: got we=%b addr=%h data=%h, required we=%b addr=%h data=%h",
                 o.we, o.addr, o.data, e.we, e.addr, e.data);
      end
    end
    repeat (6) @(negedge CLK);
    tests++;
    if (obs_q.size() != obs_rd) begin
      fails++;
      $display("[TB] FAIL rdwr_no_read: got %0d extra txns, required 0", obs_q.size() - obs_rd);
    end
  endtask

  initial begin
    test_reset();
    test_posted_writes();
    test_forward();
    test_full();
    test_load_miss();
    test_read_write_both();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
